// File: rtl/dlx_alu_pkg.sv
// Shared DLX ALU-control definitions: ALU Op codes, opcode/func codes,
// trap cause codes and the control FSM state encoding.
package dlx_alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADDU = 4'b0010;
   localparam logic [3:0] ALU_ADD  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SUBU = 4'b0111;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDUI = 6'h09;
   localparam logic [5:0] OPC_SUBI  = 6'h0A;
   localparam logic [5:0] OPC_SUBUI = 6'h0B;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_SLTI  = 6'h1A;
   localparam logic [5:0] OPC_SLTUI = 6'h1B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [1:0] TRAP_NONE = 2'b00;
   localparam logic [1:0] TRAP_OVF  = 2'b01;
   localparam logic [1:0] TRAP_ILL  = 2'b10;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/dlx_alu_decode.sv
// Combinational ID-stage decoder: opcode/func to ALU Op, carry-in,
// immediate select, trap enable and illegal-instruction flag.
module dlx_alu_decode
   import dlx_alu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   output logic [3:0] op,
   output logic       carryin,
   output logic       use_imm,
   output logic       trap_en,
   output logic       illegal
);

   // Map the instruction to its ALU operation; unknown codes fall to illegal.
   always_comb begin
      op      = ALU_AND;
      use_imm = 1'b0;
      trap_en = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            case (func)
               FN_ADD:  begin op = ALU_ADD; trap_en = 1'b1; end
               FN_ADDU: op = ALU_ADDU;
               FN_SUB:  begin op = ALU_SUB; trap_en = 1'b1; end
               FN_SUBU: op = ALU_SUBU;
               FN_AND:  op = ALU_AND;
               FN_OR:   op = ALU_OR;
               FN_SLT:  op = ALU_SLT;
               FN_SLTU: op = ALU_SLTU;
               default: illegal = 1'b1;
            endcase
         end
         OPC_ADDI:  begin op = ALU_ADD;  use_imm = 1'b1; trap_en = 1'b1; end
         OPC_ADDUI: begin op = ALU_ADDU; use_imm = 1'b1; end
         OPC_SUBI:  begin op = ALU_SUB;  use_imm = 1'b1; trap_en = 1'b1; end
         OPC_SUBUI: begin op = ALU_SUBU; use_imm = 1'b1; end
         OPC_ANDI:  begin op = ALU_AND;  use_imm = 1'b1; end
         OPC_ORI:   begin op = ALU_OR;   use_imm = 1'b1; end
         OPC_SLTI:  begin op = ALU_SLT;  use_imm = 1'b1; end
         OPC_SLTUI: begin op = ALU_SLTU; use_imm = 1'b1; end
         default:   illegal = 1'b1;
      endcase
   end

   // Subtract-type and compare operations need carry into bit 0.
   assign carryin = (op == ALU_SUB) || (op == ALU_SUBU) ||
                    (op == ALU_SLT) || (op == ALU_SLTU);

endmodule

// File: rtl/dlx_alu_ctrl.sv
// ID->EX ALU control stage: registers decoded ALU controls into the EX slot,
// watches MSB-slice overflow and raises a held trap request until acked.
module dlx_alu_ctrl
   import dlx_alu_pkg::*;
#(
   parameter int OP_W  = 4,
   parameter int OPC_W = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [OPC_W-1:0] id_opcode,
   input  logic [OPC_W-1:0] id_func,
   output logic             id_ready,
   input  logic             ex_stall,
   input  logic             ex_flush,
   output logic             ex_valid,
   output logic [OP_W-1:0]  ex_op,
   output logic             ex_carryin,
   output logic             ex_use_imm,
   input  logic             alu_overflow,
   output logic             trap_req,
   output logic [1:0]       trap_cause,
   input  logic             trap_ack,
   output logic [CNT_W-1:0] trap_count
);

   ctrl_state_e state_q, state_d;

   logic [3:0] dec_op;
   logic       dec_carryin;
   logic       dec_use_imm;
   logic       dec_trap_en;
   logic       dec_illegal;
   logic       ex_trap_en;
   logic       ex_illegal;
   logic       slot_traps;

   dlx_alu_decode u_decode (
      .opcode  (id_opcode),
      .func    (id_func),
      .op      (dec_op),
      .carryin (dec_carryin),
      .use_imm (dec_use_imm),
      .trap_en (dec_trap_en),
      .illegal (dec_illegal)
   );

   assign id_ready   = !ex_stall && (state_q == RUN);
   assign slot_traps = (state_q == RUN) && ex_valid && !ex_stall && !ex_flush &&
                       ((ex_trap_en && alu_overflow) || ex_illegal);

   // Control FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Enter TRAP when the live EX op traps; leave it only on acknowledge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (slot_traps) state_d = TRAP;
         TRAP:    if (trap_ack)   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // EX slot: a trap, a flush or the TRAP state empties it, stall holds it,
   // otherwise it takes whatever ID presents (a bubble when ID is empty).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_op      <= '0;
         ex_carryin <= 1'b0;
         ex_use_imm <= 1'b0;
         ex_trap_en <= 1'b0;
         ex_illegal <= 1'b0;
      end else if ((state_q == TRAP) || slot_traps || ex_flush || (!ex_stall && !id_valid)) begin
         ex_valid   <= 1'b0;
         ex_op      <= '0;
         ex_carryin <= 1'b0;
         ex_use_imm <= 1'b0;
         ex_trap_en <= 1'b0;
         ex_illegal <= 1'b0;
      end else if (!ex_stall) begin
         ex_valid   <= 1'b1;
         ex_op      <= OP_W'(dec_op);
         ex_carryin <= dec_carryin;
         ex_use_imm <= dec_use_imm;
         ex_trap_en <= dec_trap_en;
         ex_illegal <= dec_illegal;
      end
   end

   // Trap request, cause and saturating count; illegal outranks overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_req   <= 1'b0;
         trap_cause <= TRAP_NONE;
         trap_count <= '0;
      end else if (slot_traps) begin
         trap_req   <= 1'b1;
         trap_cause <= ex_illegal ? TRAP_ILL : TRAP_OVF;
         if (trap_count != '1) trap_count <= trap_count + 1'b1;
      end else if ((state_q == TRAP) && trap_ack) begin
         trap_req   <= 1'b0;
         trap_cause <= TRAP_NONE;
      end
   end

endmodule

// File: tb/tb_dlx_alu_ctrl.sv
// Self-checking bench for dlx_alu_ctrl: directed scenarios plus randomized
// traffic, all checked against an instruction-level reference model.
module tb_dlx_alu_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [5:0] id_opcode;
   logic [5:0] id_func;
   logic       id_ready;
   logic       ex_stall;
   logic       ex_flush;
   logic       ex_valid;
   logic [3:0] ex_op;
   logic       ex_carryin;
   logic       ex_use_imm;
   logic       alu_overflow;
   logic       trap_req;
   logic [1:0] trap_cause;
   logic       trap_ack;
   logic [7:0] trap_count;

   int passed = 0;
   int total  = 0;

   // Reference model state, tracked per instruction rather than per register.
   bit       m_trap;
   bit       m_valid;
   bit [3:0] m_op;
   bit       m_cin;
   bit       m_imm;
   bit       m_ten;
   bit       m_ill;
   bit       m_req;
   bit [1:0] m_cause;
   int       m_count;

   dlx_alu_ctrl #(.OP_W(4), .OPC_W(6), .CNT_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_opcode    (id_opcode),
      .id_func      (id_func),
      .id_ready     (id_ready),
      .ex_stall     (ex_stall),
      .ex_flush     (ex_flush),
      .ex_valid     (ex_valid),
      .ex_op        (ex_op),
      .ex_carryin   (ex_carryin),
      .ex_use_imm   (ex_use_imm),
      .alu_overflow (alu_overflow),
      .trap_req     (trap_req),
      .trap_cause   (trap_cause),
      .trap_ack     (trap_ack),
      .trap_count   (trap_count)
   );

   always #5 clk = ~clk;

   // Instruction mnemonic from opcode/func; I-types report their base operation.
   function automatic string ref_name(input bit [5:0] opc, input bit [5:0] fn, output bit imm);
      imm = 1'b0;
      if (opc == 6'h00) begin
         case (fn)
            6'h20: return "ADD";
            6'h21: return "ADDU";
            6'h22: return "SUB";
            6'h23: return "SUBU";
            6'h24: return "AND";
            6'h25: return "OR";
            6'h2A: return "SLT";
            6'h2B: return "SLTU";
            default: return "ILL";
         endcase
      end
      imm = 1'b1;
      case (opc)
         6'h08: return "ADD";
         6'h09: return "ADDU";
         6'h0A: return "SUB";
         6'h0B: return "SUBU";
         6'h0C: return "AND";
         6'h0D: return "OR";
         6'h1A: return "SLT";
         6'h1B: return "SLTU";
         default: begin imm = 1'b0; return "ILL"; end
      endcase
   endfunction

   function automatic bit [3:0] ref_op(input string nm);
      if (nm == "OR")   return 4'b0001;
      if (nm == "ADDU") return 4'b0010;
      if (nm == "ADD")  return 4'b0011;
      if (nm == "SUB")  return 4'b0100;
      if (nm == "SLT")  return 4'b0101;
      if (nm == "SLTU") return 4'b0110;
      if (nm == "SUBU") return 4'b0111;
      return 4'b0000;
   endfunction

   task automatic model_reset();
      m_trap = 0; m_valid = 0; m_op = 0; m_cin = 0; m_imm = 0;
      m_ten = 0; m_ill = 0; m_req = 0; m_cause = 0; m_count = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      string nm;
      bit    imm;
      if (m_trap) begin
         m_valid = 0;
         if (trap_ack) begin m_trap = 0; m_req = 0; m_cause = 2'b00; end
      end else if (m_valid && !ex_stall && !ex_flush && ((m_ten && alu_overflow) || m_ill)) begin
         m_trap = 1; m_req = 1; m_valid = 0;
         m_cause = m_ill ? 2'b10 : 2'b01;
         if (m_count < 255) m_count++;
      end else if (ex_flush) begin
         m_valid = 0;
      end else if (!ex_stall) begin
         if (id_valid) begin
            nm = ref_name(id_opcode, id_func, imm);
            m_valid = 1;
            m_ill = (nm == "ILL");
            m_imm = imm;
            m_op  = ref_op(nm);
            m_cin = (nm == "SUB") || (nm == "SUBU") || (nm == "SLT") || (nm == "SLTU");
            m_ten = (nm == "ADD") || (nm == "SUB");
         end else begin
            m_valid = 0;
         end
      end
   endtask

   // Drive one cycle of inputs, step the model, and sample 1 ns after the edge.
   task automatic applyStimulus(input bit v, input bit [5:0] opc, input bit [5:0] fn,
                                input bit st, input bit fl, input bit ov, input bit ak);
      id_valid = v; id_opcode = opc; id_func = fn;
      ex_stall = st; ex_flush = fl; alu_overflow = ov; trap_ack = ak;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      id_valid = 0; id_opcode = 0; id_func = 0; ex_stall = 0; ex_flush = 0;
      alu_overflow = 0; trap_ack = 0;
      model_reset();
      #12;
      total++; if (trap_req !== 1'b0) $display("[TB] FAIL reset_trap_req got %b want 0", trap_req); else passed++;
      total++; if (ex_valid !== 1'b0) $display("[TB] FAIL reset_ex_valid got %b want 0", ex_valid); else passed++;
      total++; if (ex_op !== 4'b0000) $display("[TB] FAIL reset_ex_op got %b want 0000", ex_op); else passed++;
      total++; if (trap_count !== 8'h00) $display("[TB] FAIL reset_trap_count got %h want 00", trap_count); else passed++;
      total++; if (id_ready !== 1'b1) $display("[TB] FAIL reset_id_ready got %b want 1", id_ready); else passed++;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_decode();
      applyStimulus(1, 6'h00, 6'h22, 0, 0, 0, 0);
      total++; if (ex_op !== 4'b0100) $display("[TB] FAIL dec_sub_op got %b want 0100", ex_op); else passed++;
      total++; if (ex_carryin !== 1'b1) $display("[TB] FAIL dec_sub_cin got %b want 1", ex_carryin); else passed++;
      total++; if (ex_use_imm !== 1'b0) $display("[TB] FAIL dec_sub_imm got %b want 0", ex_use_imm); else passed++;
      total++; if (ex_valid !== 1'b1) $display("[TB] FAIL dec_sub_valid got %b want 1", ex_valid); else passed++;
      applyStimulus(1, 6'h1B, 6'h00, 0, 0, 0, 0);
      total++; if (ex_op !== 4'b0110) $display("[TB] FAIL dec_sltui_op got %b want 0110", ex_op); else passed++;
      total++; if (ex_carryin !== 1'b1) $display("[TB] FAIL dec_sltui_cin got %b want 1", ex_carryin); else passed++;
      total++; if (ex_use_imm !== 1'b1) $display("[TB] FAIL dec_sltui_imm got %b want 1", ex_use_imm); else passed++;
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 0);
      total++; if (ex_valid !== 1'b0) $display("[TB] FAIL dec_bubble_valid got %b want 0", ex_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      bit [5:0] opcs [4] = '{6'h00, 6'h0D, 6'h00, 6'h09};
      bit [5:0] fns  [4] = '{6'h24, 6'h00, 6'h2A, 6'h00};
      bit [3:0] ops  [4] = '{4'b0000, 4'b0001, 4'b0101, 4'b0010};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, opcs[i], fns[i], 0, 0, 0, 0);
         total++;
         if (ex_op !== ops[i] || ex_valid !== 1'b1)
            $display("[TB] FAIL b2b_op%0d got %b/%b want %b/1", i, ex_op, ex_valid, ops[i]);
         else passed++;
      end
   endtask

   task automatic test_overflow_trap();
      applyStimulus(1, 6'h00, 6'h20, 0, 0, 0, 0);
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 1, 0);
      total++; if (trap_req !== 1'b1) $display("[TB] FAIL ovf_trap_req got %b want 1", trap_req); else passed++;
      total++; if (trap_cause !== 2'b01) $display("[TB] FAIL ovf_cause got %b want 01", trap_cause); else passed++;
      total++; if (ex_valid !== 1'b0) $display("[TB] FAIL ovf_ex_valid got %b want 0", ex_valid); else passed++;
      total++; if (id_ready !== 1'b0) $display("[TB] FAIL ovf_id_ready got %b want 0", id_ready); else passed++;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 6'h00, 6'h20, 0, (i == 1), 1, 0);
         total++;
         if (trap_req !== 1'b1 || trap_cause !== 2'b01 || ex_valid !== 1'b0)
            $display("[TB] FAIL ovf_hold%0d got req=%b cause=%b valid=%b want 1/01/0", i, trap_req, trap_cause, ex_valid);
         else passed++;
      end
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 1);
      total++; if (trap_req !== 1'b0) $display("[TB] FAIL ovf_ack_req got %b want 0", trap_req); else passed++;
      total++; if (trap_cause !== 2'b00) $display("[TB] FAIL ovf_ack_cause got %b want 00", trap_cause); else passed++;
      total++; if (trap_count !== 8'h01) $display("[TB] FAIL ovf_count got %h want 01", trap_count); else passed++;
      total++; if (id_ready !== 1'b1) $display("[TB] FAIL ovf_ack_ready got %b want 1", id_ready); else passed++;
      applyStimulus(1, 6'h00, 6'h25, 0, 0, 0, 1);
      total++; if (ex_valid !== 1'b1 || trap_req !== 1'b0) $display("[TB] FAIL ack_in_run got valid=%b req=%b want 1/0", ex_valid, trap_req); else passed++;
   endtask

   task automatic test_no_trap();
      applyStimulus(1, 6'h00, 6'h21, 0, 0, 0, 0);
      applyStimulus(1, 6'h1B, 6'h00, 0, 0, 1, 0);
      total++; if (trap_req !== 1'b0) $display("[TB] FAIL addu_ovf_req got %b want 0", trap_req); else passed++;
      total++; if (ex_valid !== 1'b1 || ex_op !== 4'b0110) $display("[TB] FAIL addu_ovf_next got %b/%b want 1/0110", ex_valid, ex_op); else passed++;
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 1, 0);
      total++; if (trap_req !== 1'b0) $display("[TB] FAIL sltui_ovf_req got %b want 0", trap_req); else passed++;
   endtask

   task automatic test_stall_flush();
      applyStimulus(1, 6'h00, 6'h22, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 6'h00, 6'h20, 1, 0, 0, 0);
         total++;
         if (ex_op !== 4'b0100 || id_ready !== 1'b0)
            $display("[TB] FAIL stall_hold%0d got op=%b ready=%b want 0100/0", i, ex_op, id_ready);
         else passed++;
      end
      applyStimulus(1, 6'h00, 6'h20, 0, 0, 0, 0);
      total++; if (ex_op !== 4'b0011) $display("[TB] FAIL stall_release got %b want 0011", ex_op); else passed++;
      applyStimulus(1, 6'h00, 6'h20, 1, 1, 1, 0);
      total++; if (ex_valid !== 1'b0 || trap_req !== 1'b0) $display("[TB] FAIL flush_ovf got valid=%b req=%b want 0/0", ex_valid, trap_req); else passed++;
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 0);
      applyStimulus(0, 6'h00, 6'h00, 1, 0, 1, 0);
      total++; if (trap_req !== 1'b0 || ex_valid !== 1'b1) $display("[TB] FAIL stall_ovf got req=%b valid=%b want 0/1", trap_req, ex_valid); else passed++;
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 1, 0);
      total++; if (trap_req !== 1'b1 || trap_cause !== 2'b01) $display("[TB] FAIL stall_reeval got req=%b cause=%b want 1/01", trap_req, trap_cause); else passed++;
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 1);
   endtask

   task automatic test_illegal();
      applyStimulus(1, 6'h3F, 6'h00, 0, 0, 0, 0);
      total++; if (ex_op !== 4'b0000 || ex_valid !== 1'b1) $display("[TB] FAIL ill_load got op=%b valid=%b want 0000/1", ex_op, ex_valid); else passed++;
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 0);
      total++; if (trap_req !== 1'b1 || trap_cause !== 2'b10) $display("[TB] FAIL ill_trap got req=%b cause=%b want 1/10", trap_req, trap_cause); else passed++;
      total++; if (trap_count !== 8'(m_count)) $display("[TB] FAIL ill_count got %h want %h", trap_count, 8'(m_count)); else passed++;
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 1);
      total++; if (trap_req !== 1'b0) $display("[TB] FAIL ill_ack got %b want 0", trap_req); else passed++;
   endtask

   task automatic test_reset_mid_trap();
      applyStimulus(1, 6'h00, 6'h3C, 0, 0, 0, 0);
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 0);
      total++; if (trap_req !== 1'b1) $display("[TB] FAIL midtrap_setup got %b want 1", trap_req); else passed++;
      rst_n = 1'b0;
      model_reset();
      #2;
      total++; if (trap_req !== 1'b0) $display("[TB] FAIL midtrap_req got %b want 0", trap_req); else passed++;
      total++; if (ex_valid !== 1'b0) $display("[TB] FAIL midtrap_valid got %b want 0", ex_valid); else passed++;
      total++; if (trap_count !== 8'h00) $display("[TB] FAIL midtrap_count got %h want 00", trap_count); else passed++;
      total++; if (id_ready !== 1'b1) $display("[TB] FAIL midtrap_ready got %b want 1", id_ready); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      bit [5:0] legal [16] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h1A, 6'h1B,
                               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};
      bit [5:0] opc, fn;
      int       pick;
      for (int n = 0; n < 600; n++) begin
         pick = $urandom_range(0, 19);
         if (pick < 8)       begin opc = legal[pick]; fn = 6'($urandom); end
         else if (pick < 16) begin opc = 6'h00; fn = legal[pick]; end
         else if (pick < 18) begin opc = 6'($urandom); fn = 6'($urandom); end
         else                begin opc = 6'h00; fn = 6'($urandom); end
         applyStimulus(($urandom_range(0, 9) < 8), opc, fn, ($urandom_range(0, 9) < 2),
                       ($urandom_range(0, 9) < 1), ($urandom_range(0, 9) < 4),
                       ($urandom_range(0, 9) < 3));
         total++;
         if (ex_valid !== m_valid || trap_req !== m_req || trap_cause !== m_cause ||
             trap_count !== 8'(m_count) || id_ready !== (!ex_stall && !m_trap))
            $display("[TB] FAIL rnd_ctrl%0d got v=%b r=%b c=%b n=%h rdy=%b want v=%b r=%b c=%b n=%h rdy=%b",
                     n, ex_valid, trap_req, trap_cause, trap_count, id_ready,
                     m_valid, m_req, m_cause, 8'(m_count), !ex_stall && !m_trap);
         else passed++;
         if (m_valid) begin
            total++;
            if (ex_op !== m_op || (!m_ill && (ex_carryin !== m_cin || ex_use_imm !== m_imm)))
               $display("[TB] FAIL rnd_fields%0d got op=%b cin=%b imm=%b want op=%b cin=%b imm=%b",
                        n, ex_op, ex_carryin, ex_use_imm, m_op, m_cin, m_imm);
            else passed++;
         end
      end
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 1);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 260; i++) begin
         applyStimulus(1, 6'h3F, 6'h00, 0, 0, 0, 0);
         applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 0);
         applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 1);
      end
      total++; if (trap_count !== 8'hFF) $display("[TB] FAIL sat_count got %h want FF", trap_count); else passed++;
      applyStimulus(1, 6'h3F, 6'h00, 0, 0, 0, 0);
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 0);
      total++; if (trap_req !== 1'b1 || trap_count !== 8'hFF) $display("[TB] FAIL sat_more got req=%b n=%h want 1/FF", trap_req, trap_count); else passed++;
      applyStimulus(0, 6'h00, 6'h00, 0, 0, 0, 1);
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_overflow_trap();
      test_no_trap();
      test_stall_flush();
      test_illegal();
      test_reset_mid_trap();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
